// File: rtl/chip8_loader.sv
// CHIP-8 program loader: optional RAM clear, hex-font copy, then host byte stream into CPU RAM.
// Define CHIP8_LOADER_CLEAR_EN to zero all 4 KiB of RAM before the font copy.
module chip8_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h200,
    parameter logic [11:0] FONT_ADDR = 12'h000
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [11:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        uploading,
    output logic        upload_en,
    output logic [11:0] upload_addr,
    output logic [7:0]  upload_data,
    output logic        overflow
);

    localparam int unsigned AW       = 12;
    localparam int unsigned DW       = 8;
    localparam int unsigned FIW      = 7;
    localparam int unsigned FONT_LEN = 80;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
`ifdef CHIP8_LOADER_CLEAR_EN
        CLEAR  = 3'd1,
`endif
        FONT   = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    state_t         state;
    logic           dl_active_q;
    logic           fell;
    logic [FIW-1:0] font_idx;
    logic [3:0]     glyph;
    logic [2:0]     row;
`ifdef CHIP8_LOADER_CLEAR_EN
    logic [AW-1:0]  clr_cnt;
`endif

    logic           rise_c;
    logic [AW:0]    sum_c;
    logic           font_step_c;
    logic [AW-1:0]  font_addr_c;
    logic [DW-1:0]  font_data_c;

    // Five rows per glyph, top row in the most significant byte.
    function automatic logic [39:0] glyph_rows(input logic [3:0] g);
        case (g)
            4'h0:    glyph_rows = 40'hF0_90_90_90_F0;
            4'h1:    glyph_rows = 40'h20_60_20_20_70;
            4'h2:    glyph_rows = 40'hF0_10_F0_80_F0;
            4'h3:    glyph_rows = 40'hF0_10_F0_10_F0;
            4'h4:    glyph_rows = 40'h90_90_F0_10_10;
            4'h5:    glyph_rows = 40'hF0_80_F0_10_F0;
            4'h6:    glyph_rows = 40'hF0_80_F0_90_F0;
            4'h7:    glyph_rows = 40'hF0_10_20_40_40;
            4'h8:    glyph_rows = 40'hF0_90_F0_90_F0;
            4'h9:    glyph_rows = 40'hF0_90_F0_10_F0;
            4'hA:    glyph_rows = 40'hF0_90_F0_90_90;
            4'hB:    glyph_rows = 40'hE0_90_E0_90_E0;
            4'hC:    glyph_rows = 40'hF0_80_80_80_F0;
            4'hD:    glyph_rows = 40'hE0_90_90_90_E0;
            4'hE:    glyph_rows = 40'hF0_80_F0_80_F0;
            default: glyph_rows = 40'hF0_80_F0_80_80;
        endcase
    endfunction

    function automatic logic [7:0] font_byte(input logic [3:0] g, input logic [2:0] r);
        logic [39:0] rows;
        rows = glyph_rows(g);
        case (r)
            3'd0:    font_byte = rows[39:32];
            3'd1:    font_byte = rows[31:24];
            3'd2:    font_byte = rows[23:16];
            3'd3:    font_byte = rows[15:8];
            default: font_byte = rows[7:0];
        endcase
    endfunction

    // A font write is issued on every FONT cycle and on the cycle that enters FONT.
    always_comb begin
        rise_c      = (state == IDLE) && dl_active && !dl_active_q;
        sum_c       = {1'b0, BASE_ADDR} + {1'b0, dl_addr};
        font_addr_c = FONT_ADDR + AW'(font_idx);
        font_data_c = font_byte(glyph, row);
`ifdef CHIP8_LOADER_CLEAR_EN
        font_step_c = ((state == FONT) && (font_idx != FIW'(FONT_LEN)))
                   || ((state == CLEAR) && (clr_cnt == '0));
`else
        font_step_c = ((state == FONT) && (font_idx != FIW'(FONT_LEN))) || rise_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state       <= IDLE;
            dl_active_q <= dl_active;
            fell        <= 1'b0;
            font_idx    <= '0;
            glyph       <= '0;
            row         <= '0;
`ifdef CHIP8_LOADER_CLEAR_EN
            clr_cnt     <= '0;
`endif
            dl_wait     <= 1'b0;
            uploading   <= 1'b0;
            upload_en   <= 1'b0;
            upload_addr <= '0;
            upload_data <= '0;
            overflow    <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            upload_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_c) begin
                        uploading <= 1'b1;
                        dl_wait   <= 1'b1;
                        overflow  <= 1'b0;
                        fell      <= 1'b0;
`ifdef CHIP8_LOADER_CLEAR_EN
                        state       <= CLEAR;
                        upload_en   <= 1'b1;
                        upload_addr <= '0;
                        upload_data <= '0;
                        clr_cnt     <= AW'(1);
`else
                        state <= FONT;
`endif
                    end
                end
`ifdef CHIP8_LOADER_CLEAR_EN
                // clr_cnt wraps to zero once address 4095 has been issued.
                CLEAR: begin
                    if (!dl_active) fell <= 1'b1;
                    if (clr_cnt == '0) begin
                        state <= FONT;
                    end else begin
                        upload_en   <= 1'b1;
                        upload_addr <= clr_cnt;
                        upload_data <= '0;
                        clr_cnt     <= clr_cnt + AW'(1);
                    end
                end
`endif
                FONT: begin
                    if (font_idx == FIW'(FONT_LEN)) begin
                        font_idx <= '0;
                        if (fell || !dl_active) begin
                            state <= FLUSH;
                        end else begin
                            state   <= STREAM;
                            dl_wait <= 1'b0;
                        end
                    end else if (!dl_active) begin
                        fell <= 1'b1;
                    end
                end
                STREAM: begin
                    if (dl_wr) begin
                        if (sum_c[AW]) begin
                            overflow <= 1'b1;
                        end else begin
                            upload_en   <= 1'b1;
                            upload_addr <= sum_c[AW-1:0];
                            upload_data <= dl_data;
                        end
                    end
                    if (!dl_active) begin
                        state   <= FLUSH;
                        dl_wait <= 1'b1;
                    end
                end
                FLUSH: begin
                    state     <= IDLE;
                    dl_wait   <= 1'b0;
                    uploading <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    dl_wait   <= 1'b0;
                    uploading <= 1'b0;
                end
            endcase
            if (font_step_c) begin
                upload_en   <= 1'b1;
                upload_addr <= font_addr_c;
                upload_data <= font_data_c;
                font_idx    <= font_idx + FIW'(1);
                if (row == 3'd4) begin
                    row   <= '0;
                    glyph <= glyph + 4'd1;
                end else begin
                    row <= row + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chip8_loader.sv
// Self-checking bench for chip8_loader: window-based behavioural model plus directed and random transfers.
module tb_chip8_loader;

    localparam int BASE  = 'h200;
    localparam int FONT  = 'h000;
`ifdef CHIP8_LOADER_CLEAR_EN
    localparam int NCLR  = 4096;
`else
    localparam int NCLR  = 0;
`endif
    localparam int NPREP = NCLR + 80;
    localparam int LIMIT = 6000;
    localparam int RST_AT = (NCLR > 0) ? 100 : 40;
    localparam logic [11:0] RST_ADDR = (NCLR > 0) ? 12'd100 : 12'h028;
    localparam logic [639:0] FONT_BITS = {
        40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
        40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
        40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
        40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080};

    logic        clk;
    logic        res_n;
    logic        dl_active;
    logic        dl_wr;
    logic [11:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        uploading;
    logic        upload_en;
    logic [11:0] upload_addr;
    logic [7:0]  upload_data;
    logic        overflow;

    chip8_loader dut (
        .clk         (clk),
        .res_n       (res_n),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_wait     (dl_wait),
        .uploading   (uploading),
        .upload_en   (upload_en),
        .upload_addr (upload_addr),
        .upload_data (upload_data),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        int          t;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    bit  exp_reset = 1'b0;
    bit  busy = 1'b0;
    bit  streaming = 1'b0;
    bit  in_flush = 1'b0;
    bit  fell = 1'b0;
    bit  e_ovf = 1'b0;
    bit  prev = 1'b0;
    int  prep_end = 0;

    int  lit_tests = 0;
    int  lit_fails = 0;
    int  cmp_tests = 0;
    int  cmp_fails = 0;

    function automatic logic [7:0] font_ref(input int j);
        logic [639:0] bits;
        bits = FONT_BITS;
        return bits[639 - 8*j -: 8];
    endfunction

    // Model: a transfer is a busy window; prep writes are scheduled up front, stream writes as they arrive.
    always @(posedge clk) begin : model
        int  s;
        wr_t w;
        cyc++;
        if (!res_n) begin
            exp_reset = 1'b1;
            busy = 1'b0; streaming = 1'b0; in_flush = 1'b0; fell = 1'b0; e_ovf = 1'b0;
        end else begin
            exp_reset = 1'b0;
            if (in_flush) begin
                busy = 1'b0;
                in_flush = 1'b0;
            end else if (busy && !streaming) begin
                if (cyc < prep_end) begin
                    if (!dl_active) fell = 1'b1;
                end else if (fell || !dl_active) begin
                    in_flush = 1'b1;
                end else begin
                    streaming = 1'b1;
                end
            end else if (streaming) begin
                if (dl_wr) begin
                    s = BASE + int'(dl_addr);
                    if (s > 4095) e_ovf = 1'b1;
                    else begin
                        w.a = 12'(s); w.d = dl_data; w.t = cyc;
                        q.push_back(w);
                    end
                end
                if (!dl_active) begin
                    streaming = 1'b0;
                    in_flush = 1'b1;
                end
            end else if (!busy && dl_active && !prev) begin
                busy = 1'b1; fell = 1'b0; e_ovf = 1'b0;
                prep_end = cyc + NPREP;
                for (int k = 0; k < NPREP; k++) begin
                    if (k < NCLR) begin
                        w.a = 12'(k); w.d = 8'h00;
                    end else begin
                        w.a = 12'(FONT + k - NCLR); w.d = font_ref(k - NCLR);
                    end
                    w.t = cyc + k;
                    q.push_back(w);
                end
            end
        end
        prev = dl_active;
    end

    task automatic cchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_tests++;
        if (act !== exp) begin
            cmp_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic lchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_tests++;
        if (act !== exp) begin
            lit_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int          rd = 0;
    bit          e_en;
    logic [11:0] la = '0;
    logic [7:0]  ld = '0;

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (exp_reset) begin
                rd = q.size();
                la = '0;
                ld = '0;
            end
            while (rd < q.size() && q[rd].t < cyc) rd++;
            e_en = (rd < q.size()) && (q[rd].t == cyc);
            if (e_en) begin
                la = q[rd].a;
                ld = q[rd].d;
                rd++;
            end
            cchk("upload_en",   32'(upload_en),   32'(e_en));
            cchk("upload_addr", 32'(upload_addr), 32'(la));
            cchk("upload_data", 32'(upload_data), 32'(ld));
            cchk("uploading",   32'(uploading),   32'(busy));
            cchk("dl_wait",     32'(dl_wait),     32'(busy && !streaming));
            cchk("overflow",    32'(overflow),    32'(e_ovf));
        end
    end

    task automatic wait_stream(input string name);
        int m = 0;
        while (dl_wait && m < LIMIT) begin
            @(negedge clk);
            m++;
        end
        lchk(name, 32'(m < LIMIT), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int m = 0;
        while (uploading && m < LIMIT) begin
            @(negedge clk);
            m++;
        end
        lchk(name, 32'(m < LIMIT), 32'd1);
    endtask

    task automatic rand_addr();
        if ($urandom_range(0, 3) == 0) dl_addr = 12'($urandom_range('hE00, 'hFFF));
        else                           dl_addr = 12'($urandom_range(0, 'hDFF));
    endtask

    task automatic rand_stream(input int n);
        repeat (n) begin
            dl_wr   = 1'($urandom_range(0, 1));
            rand_addr();
            dl_data = 8'($urandom);
            @(negedge clk);
        end
        dl_wr = 1'b0;
    endtask

    initial begin
        int m;
        res_n = 1'b0; dl_active = 1'b1; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        repeat (3) @(negedge clk);
        lchk("rst_uploading", 32'(uploading), 32'd0);
        lchk("rst_en",        32'(upload_en), 32'd0);
        lchk("rst_addr",      32'(upload_addr), 32'd0);
        lchk("rst_data",      32'(upload_data), 32'd0);
        lchk("rst_wait",      32'(dl_wait), 32'd0);
        lchk("rst_ovf",       32'(overflow), 32'd0);
        res_n = 1'b1;
        repeat (10) @(negedge clk);
        lchk("no_start_when_high", 32'(uploading), 32'd0);
        dl_active = 1'b0;
        repeat (2) @(negedge clk);

        // Prep phase with pinned font bytes and exact dl_wait length.
        dl_active = 1'b1;
        @(negedge clk);
        m = 0;
        lchk("prep_first_en", 32'(upload_en), 32'd1);
        lchk("prep_first_wait", 32'(dl_wait), 32'd1);
        if (NCLR > 0) begin
            lchk("clear_first_addr", 32'(upload_addr), 32'h000);
            lchk("clear_first_data", 32'(upload_data), 32'h00);
        end
        while (dl_wait && m < LIMIT) begin
            if (m == NCLR) begin
                lchk("font0_addr", 32'(upload_addr), 32'h000);
                lchk("font0_data", 32'(upload_data), 32'hF0);
            end
            if (m == NPREP - 1) begin
                lchk("font79_addr", 32'(upload_addr), 32'h04F);
                lchk("font79_data", 32'(upload_data), 32'h80);
            end
            @(negedge clk);
            m++;
        end
        lchk("prep_length", 32'(m), 32'(NPREP));

        // Back-to-back stream writes.
        dl_wr = 1'b1; dl_addr = 12'd0; dl_data = 8'hAA;
        @(negedge clk);
        lchk("b2b0_addr", 32'(upload_addr), 32'h200);
        lchk("b2b0_data", 32'(upload_data), 32'hAA);
        dl_addr = 12'd1; dl_data = 8'hBB;
        @(negedge clk);
        lchk("b2b1_addr", 32'(upload_addr), 32'h201);
        lchk("b2b1_data", 32'(upload_data), 32'hBB);
        dl_addr = 12'd2; dl_data = 8'hCC;
        @(negedge clk);
        lchk("b2b2_en",   32'(upload_en), 32'd1);
        lchk("b2b2_addr", 32'(upload_addr), 32'h202);
        lchk("b2b2_data", 32'(upload_data), 32'hCC);
        dl_wr = 1'b0;
        @(negedge clk);
        lchk("b2b_idle_en", 32'(upload_en), 32'd0);

        // Top-of-RAM boundary and overflow.
        dl_wr = 1'b1; dl_addr = 12'hDFF; dl_data = 8'h3C;
        @(negedge clk);
        lchk("top_en",   32'(upload_en), 32'd1);
        lchk("top_addr", 32'(upload_addr), 32'hFFF);
        lchk("top_ovf",  32'(overflow), 32'd0);
        dl_addr = 12'hE00; dl_data = 8'h77;
        @(negedge clk);
        lchk("ovf_en",   32'(upload_en), 32'd0);
        lchk("ovf_flag", 32'(overflow), 32'd1);
        lchk("ovf_hold_addr", 32'(upload_addr), 32'hFFF);
        lchk("ovf_hold_data", 32'(upload_data), 32'h3C);
        dl_wr = 1'b0;
        rand_stream(40);

        // Final byte coincides with the dl_active fall.
        dl_wr = 1'b1; dl_addr = 12'd4; dl_data = 8'h5A; dl_active = 1'b0;
        @(negedge clk);
        lchk("last_en",   32'(upload_en), 32'd1);
        lchk("last_addr", 32'(upload_addr), 32'h204);
        lchk("last_data", 32'(upload_data), 32'h5A);
        lchk("flush_uploading", 32'(uploading), 32'd1);
        lchk("flush_wait", 32'(dl_wait), 32'd1);
        dl_wr = 1'b0;
        @(negedge clk);
        lchk("done_uploading", 32'(uploading), 32'd0);
        lchk("done_en", 32'(upload_en), 32'd0);
        lchk("done_wait", 32'(dl_wait), 32'd0);
        repeat (3) @(negedge clk);

        // dl_active falls mid-prep: sequence completes, then straight to FLUSH.
        dl_active = 1'b1;
        repeat ($urandom_range(5, NPREP - 5)) @(negedge clk);
        dl_active = 1'b0;
        wait_idle("midprep_fall_bound");
        repeat (3) @(negedge clk);

        // Brief drop and recovery mid-prep still ends the transfer.
        dl_active = 1'b1;
        repeat ($urandom_range(5, NPREP - 10)) @(negedge clk);
        dl_active = 1'b0;
        repeat (3) @(negedge clk);
        dl_active = 1'b1;
        wait_idle("midprep_glitch_bound");
        dl_active = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of prep.
        dl_active = 1'b1;
        @(negedge clk);
        repeat (RST_AT) @(negedge clk);
        lchk("pre_reset_addr", 32'(upload_addr), 32'(RST_ADDR));
        res_n = 1'b0;
        @(negedge clk);
        lchk("abort_uploading", 32'(uploading), 32'd0);
        lchk("abort_en", 32'(upload_en), 32'd0);
        res_n = 1'b1;
        repeat (20) @(negedge clk);
        lchk("no_restart", 32'(uploading), 32'd0);
        dl_active = 1'b0;
        repeat (3) @(negedge clk);

        // Randomised full transfers.
        repeat (2) begin
            dl_active = 1'b1;
            @(negedge clk);
            wait_stream("rand_prep_bound");
            rand_stream(int'($urandom_range(20, 80)));
            dl_wr = 1'($urandom_range(0, 1));
            rand_addr();
            dl_data = 8'($urandom);
            dl_active = 1'b0;
            @(negedge clk);
            dl_wr = 1'b0;
            wait_idle("rand_flush_bound");
            repeat (int'($urandom_range(2, 6))) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", lit_tests + cmp_tests, lit_fails + cmp_fails);
        $finish;
    end

endmodule
